// File: rtl/audio_i2s_tx_if.sv
// Stereo sample stream into the I2S transmitter: valid/ready handshake
// carrying one left/right pair per transfer.
interface audio_i2s_tx_if;
    logic               in_valid;
    logic               in_ready;
    logic signed [15:0] audio_left;
    logic signed [15:0] audio_right;

    // Sample producer
    modport master (
        output in_valid,
        output audio_left,
        output audio_right,
        input  in_ready
    );

    // I2S transmitter
    modport slave (
        input  in_valid,
        input  audio_left,
        input  audio_right,
        output in_ready
    );
endinterface

// File: rtl/audio_i2s_tx.sv
// Left-justified I2S transmitter, 16 bits per channel.
// A 9-bit divider derives mclk (clk/4), sck (clk/16) and lrck (clk/512).
// A one-deep holding register decouples the sample source from the frame
// currently being shifted out; the frame registers reload only at the
// divider wrap (511 -> 0). An empty holding register at that point is an
// underrun: the previous frame repeats, or silence is sent when
// MUTE_ON_UNDERRUN is set.
module audio_i2s_tx #(
    parameter bit MUTE_ON_UNDERRUN = 1'b0
) (
    input  logic                clk,
    input  logic                rst,
    audio_i2s_tx_if.slave       bus,
    input  logic                mute,
    output logic                mclk,
    output logic                lrck,
    output logic                sck,
    output logic                sdin,
    output logic                frame_start,
    output logic                underrun,
    output logic [15:0]         underrun_cnt
);

    // Saturating increment for the underrun counter
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic        [8:0]  div_cnt;
    logic signed [15:0] hold_l;
    logic signed [15:0] hold_r;
    logic               hold_full;
    logic signed [15:0] frame_l;
    logic signed [15:0] frame_r;
    logic               boundary;
    logic               accept;
    logic        [3:0]  bit_idx;

    // The cycle in which div_cnt = 511; the edge ending it is the frame boundary
    assign boundary = (div_cnt == 9'd511);

    // Ready is forced low during reset so no sample can slip in
    assign bus.in_ready = !hold_full && !rst;
    assign accept       = bus.in_valid && bus.in_ready;

    // Clock outputs come straight from divider flops, so they cannot glitch
    assign mclk = div_cnt[1];
    assign sck  = div_cnt[3];
    assign lrck = div_cnt[8];

    // MSB first: bit 15 - div_cnt[7:4], and 15 - x equals ~x for 4 bits
    assign bit_idx = ~div_cnt[7:4];
    assign sdin    = lrck ? frame_r[bit_idx] : frame_l[bit_idx];

    // Free-running frame divider, wraps 511 -> 0 by overflow
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 9'd1;
        end
    end

    // Holding register: filled by the handshake, emptied at a frame boundary
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_l    <= '0;
            hold_r    <= '0;
            hold_full <= 1'b0;
        end else if (accept) begin
            hold_l    <= bus.audio_left;
            hold_r    <= bus.audio_right;
            hold_full <= 1'b1;
        end else if (boundary && hold_full) begin
            hold_full <= 1'b0;
        end
    end

    // Frame reload, underrun accounting and the boundary status pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_l      <= '0;
            frame_r      <= '0;
            frame_start  <= 1'b0;
            underrun     <= 1'b0;
            underrun_cnt <= '0;
        end else begin
            frame_start <= boundary;
            underrun    <= boundary && !hold_full;
            if (boundary) begin
                if (hold_full) begin
                    // Hold is consumed even when the frame is muted
                    frame_l <= mute ? '0 : hold_l;
                    frame_r <= mute ? '0 : hold_r;
                end else begin
                    underrun_cnt <= sat_inc16(underrun_cnt);
                    if (mute || MUTE_ON_UNDERRUN) begin
                        frame_l <= '0;
                        frame_r <= '0;
                    end
                end
            end
        end
    end

endmodule

// File: doc/audio_i2s_tx.md
AUDIO_I2S_TX -- requirements
Module: audio_i2s_tx

Interface
REQ-001 The block SHALL have exactly one parameter: MUTE_ON_UNDERRUN, default 0, where 1 means load zero on underrun and 0 means repeat the last frame.
REQ-002 The block SHALL have one clock; reset is synchronous and active-high.
REQ-003 clk  input  1  system clock, 100 MHz; all state updates on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  a stereo sample is offered.
REQ-006 in_ready  output  1  the holding register can accept a sample.
REQ-007 audio_left  input  16  left sample, two's complement (for example, the mixed audio output).
REQ-008 audio_right  input  16  right sample, two's complement.
REQ-009 mute  input  1  force silence at the next frame boundary.
REQ-010 mclk  output  1  master clock, clk/4.
REQ-011 lrck  output  1  word select, clk/512; 0 = left, 1 = right.
REQ-012 sck  output  1  serial bit clock, clk/16.
REQ-013 sdin  output  1  serial data out.
REQ-014 frame_start  output  1  one-cycle pulse when a new frame is loaded.
REQ-015 underrun  output  1  one-cycle pulse when a boundary finds the holding register empty.
REQ-016 underrun_cnt  output  16  saturating count of underruns.

Function
REQ-017 The block SHALL keep a 9-bit free-running counter div_cnt that counts 0..511 and wraps from 511 to 0.
REQ-018 The clock outputs SHALL be mclk = div_cnt[1], sck = div_cnt[3] and lrck = div_cnt[8], all taken directly from the register with no glitches.
REQ-019 Data SHALL be sent left-justified, MSB first, 16 bits per channel, one bit per sck period, with the MSB starting at the lrck edge.
REQ-020 sdin SHALL equal bit (15 - div_cnt[7:4]) of frame_l when lrck = 0, and of frame_r when lrck = 1.
REQ-021 sdin SHALL therefore change only when div_cnt[3:0] = 0, that is, at sck falling edges.
REQ-022 The holding register (hold_l, hold_r, hold_full) SHALL drive in_ready = !hold_full, and in_ready SHALL be 0 while rst = 1.
REQ-023 Handshake: when in_valid and in_ready are both 1 at an edge, the block SHALL capture audio_left and audio_right into hold and set hold_full.
REQ-024 in_valid without in_ready SHALL have no effect, and the source SHALL hold its data stable until accepted.
REQ-025 Frame boundary: the block SHALL treat the edge where div_cnt goes from 511 to 0 as the frame boundary.
REQ-026 At a frame boundary with hold_full = 1, the block SHALL move hold into frame_l and frame_r and clear hold_full, so in_ready rises in the next cycle.
REQ-027 At a frame boundary with hold_full = 0, the block SHALL pulse underrun, increment underrun_cnt (saturating at 0xFFFF), and either keep frame_l/frame_r (MUTE_ON_UNDERRUN = 0) or load zero (MUTE_ON_UNDERRUN = 1).
REQ-028 If mute = 1 at a frame boundary, the block SHALL load frame_l and frame_r with zero, still consume hold if it is full, and still apply the underrun logic.
REQ-029 Simultaneous boundary and handshake: hold_full = 1 makes in_ready = 0, so no capture can occur; with hold_full = 0, the capture goes into hold and not into the frame.
REQ-030 frame_start SHALL pulse in the cycle after every frame boundary, that is, while div_cnt = 0, whether the boundary found hold full or empty.
REQ-031 Latency: a sample accepted at an edge where div_cnt = n SHALL begin on sdin at the next div_cnt = 0, after 512 - n clk cycles.
REQ-032 Because hold holds at most one sample, the steady-state acceptance rate SHALL be one sample per 512 clk.

Reset
REQ-033 While rst = 1, the block SHALL clear div_cnt, hold, hold_full, frame_l, frame_r, underrun_cnt, underrun and frame_start to 0, and hold mclk, sck, lrck and sdin at 0.
REQ-034 On the first cycle after rst is released, in_ready SHALL be 1 and div_cnt SHALL be 1.
REQ-035 The first boundary after reset is reached at div_cnt 511 to 0.
REQ-036 Reset asserted mid-frame SHALL abort the serialization immediately, discard hold, and restart timing from div_cnt = 0.

Verification
REQ-037 Clock ratios: after reset -> mclk period 4, sck period 16 and lrck period 512 clk, with lrck high for exactly 256 clk.
REQ-038 Serialization: send L = 0xA5C3, R = 0x1234 -> after the next frame_start, sdin over the 32 sck periods shows 1010010111000011 then 0001001000110100, each bit lasting 16 clk.
REQ-039 Underrun repeat: one sample, then no in_valid for three frames with MUTE_ON_UNDERRUN = 0 -> the same sample is repeated, underrun pulses three times, and underrun_cnt = 3.
REQ-040 Mute and MUTE_ON_UNDERRUN = 1: with mute = 1 at a boundary while hold is full -> sdin = 0 for the whole frame and hold is consumed; with MUTE_ON_UNDERRUN = 1 and hold empty -> sdin = 0.
REQ-041 Backpressure: in_valid held at 1 continuously -> exactly one handshake per 512 clk, and in_ready = 0 from capture until the cycle after each boundary.
REQ-042 Reset mid-frame: assert rst at div_cnt = 300 with hold full -> all outputs are 0 and underrun_cnt = 0; after release, timing restarts from div_cnt 0, and the first boundary reports an underrun if no sample is sent.
